// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared definitions for the multi-cycle RV32I control unit.
//               Provides the opcode constants, the control FSM state type,
//               and the select encodings for the datapath muxes, the ALU
//               operation class and the immediate format.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

   // Base opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam int STATE_BITS = 4;

   typedef enum logic [STATE_BITS-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JALR     = 4'd10,
      S_JUMP     = 4'd11,
      S_LUI      = 4'd12,
      S_FAULT    = 4'd13
   } state_t;

   // ResultSrc
   localparam logic [2:0] RES_ALUOUT    = 3'b000;
   localparam logic [2:0] RES_DATA      = 3'b001;
   localparam logic [2:0] RES_ALURESULT = 3'b010;
   localparam logic [2:0] RES_IMMEXT    = 3'b011;

   // ALUSrcA
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALUSrcB
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ALUOp
   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   // ImmSrc
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm_if
// Description : Bundle between the control FSM and the multi-cycle datapath.
//               master : the control unit (consumes op/mem_ready, drives
//                        enables, mux selects, ALUOp, ImmSrc and status)
//               slave  : the datapath side (drives op/mem_ready)
// Ports       : none (signals: op, mem_ready, PCUpdate, Branch, AdrSrc,
//               MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
//               ALUOp, ImmSrc, instr_done, illegal_instr, state_dbg)
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_fsm_if #(
   parameter int STATE_W = 4
);
   logic [6:0]         op;
   logic               mem_ready;
   logic               PCUpdate;
   logic               Branch;
   logic               AdrSrc;
   logic               MemWrite;
   logic               IRWrite;
   logic               RegWrite;
   logic [2:0]         ResultSrc;
   logic [1:0]         ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ALUOp;
   logic [2:0]         ImmSrc;
   logic               instr_done;
   logic               illegal_instr;
   logic [STATE_W-1:0] state_dbg;

   modport master (
      input  op, mem_ready,
      output PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
             instr_done, illegal_instr, state_dbg
   );

   modport slave (
      output op, mem_ready,
      input  PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
             instr_done, illegal_instr, state_dbg
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_fsm_imm_src_decoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_src_decoder
// Description : Combinational opcode -> immediate format select. Kept
//               separate so the pipelined core can reuse it.
// Ports       : op      in  7  opcode
//               imm_src out 3  I/S/B/J/U format select
// Revision    : 1.0 - initial release
// ============================================================================
module imm_src_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op,
   output logic [2:0] imm_src
);
   always_comb begin
      imm_src = IMM_I;
      case (op)
         OP_STORE:          imm_src = IMM_S;
         OP_BRANCH:         imm_src = IMM_B;
         OP_JAL:            imm_src = IMM_J;
         OP_LUI, OP_AUIPC:  imm_src = IMM_U;
         default:           imm_src = IMM_I;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Moore control unit for the multi-cycle RV32I core. Sequences
//               fetch/decode/execute/memory/writeback on a shared memory
//               port and ALU, with optional memory-ready wait states and
//               sticky illegal-opcode trapping.
// Ports       : clk    in  core clock
//               reset  in  synchronous, active-high
//               ctrl   master modport of multicycle_control_fsm_if
//                      (op/mem_ready in; enables, selects, ALUOp, ImmSrc,
//                       instr_done, illegal_instr, state_dbg out)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int SUPPORT_UTYPE = 1,
   parameter int MEM_HANDSHAKE = 0,
   parameter int STATE_W       = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   multicycle_control_fsm_if.master  ctrl
);
   state_t     state_q, state_d;
   logic       w_ready;
   logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write;
   logic [2:0] result_src;
   logic [1:0] alu_src_a, alu_src_b, alu_op;
   logic       instr_done, illegal_instr;

   assign w_ready = (MEM_HANDSHAKE != 0) ? ctrl.mem_ready : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      pc_update     = 1'b0;
      branch        = 1'b0;
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      result_src    = RES_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RS2;
      alu_op        = ALUOP_ADD;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            if (w_ready) begin
               ir_write  = 1'b1;
               pc_update = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (ctrl.op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JUMP;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = (SUPPORT_UTYPE != 0) ? S_LUI   : S_FAULT;
               // AUIPC's OldPC+imm is already in ALUOut after this cycle
               OP_AUIPC:          state_d = (SUPPORT_UTYPE != 0) ? S_ALUWB : S_FAULT;
               default:           state_d = S_FAULT;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = (ctrl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (w_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            // Strobe held through wait cycles; memory commits on the ready cycle
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (w_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_BRANCH;
            branch     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = S_JUMP;
         end
         S_JUMP: begin
            // PC takes the target in ALUOut while the ALU forms OldPC+4 for the link
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            result_src = RES_IMMEXT;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_FAULT: begin
            illegal_instr = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      // Reset overrides every side-effecting strobe so an abandoned
      // instruction leaves no partial writes.
      if (reset) begin
         pc_update  = 1'b0;
         branch     = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
      end
   end

   imm_src_decoder u_imm_src_decoder (
      .op      (ctrl.op),
      .imm_src (ctrl.ImmSrc)
   );

   assign ctrl.PCUpdate      = pc_update;
   assign ctrl.Branch        = branch;
   assign ctrl.AdrSrc        = adr_src;
   assign ctrl.MemWrite      = mem_write;
   assign ctrl.IRWrite       = ir_write;
   assign ctrl.RegWrite      = reg_write;
   assign ctrl.ResultSrc     = result_src;
   assign ctrl.ALUSrcA       = alu_src_a;
   assign ctrl.ALUSrcB       = alu_src_b;
   assign ctrl.ALUOp         = alu_op;
   assign ctrl.instr_done    = instr_done;
   assign ctrl.illegal_instr = illegal_instr;
   assign ctrl.state_dbg     = STATE_W'(state_q);
endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Control unit for the next-generation multi-cycle RV32I core. It replaces the single-cycle main decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles on a shared memory port and ALU. It adds an optional memory-ready handshake and illegal-opcode trapping. It sits between the instruction register (op field) and the multi-cycle datapath muxes/enables; the ALU decoder consumes its ALUOp.

Parameters:
SUPPORT_UTYPE, 1, 1 = LUI/AUIPC legal; 0 = both trap as illegal
MEM_HANDSHAKE, 0, 1 = memory states wait on mem_ready; 0 = mem_ready ignored (treated as 1)
STATE_W, 4, width of the state_dbg output

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
op  in  7  opcode field of the instruction register
mem_ready  in  1  memory access completes this cycle
PCUpdate  out  1  unconditional PC write (datapath: PCWrite = PCUpdate | Branch&take)
Branch  out  1  conditional-branch evaluate cycle
AdrSrc  out  1  memory address: 0 = PC, 1 = Result
MemWrite  out  1  store strobe
IRWrite  out  1  latch instruction register and OldPC
RegWrite  out  1  register-file write
ResultSrc  out  3  000 ALUOut, 001 Data, 010 ALUResult, 011 ImmExt
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from op, all states)
instr_done  out  1  one-cycle pulse on the final cycle of every instruction
illegal_instr  out  1  sticky trap flag
state_dbg  out  STATE_W  current state encoding

Behaviour:
- Reset: at a clk edge with reset=1, state <= FETCH and illegal_instr <= 0. While reset is high, MemWrite, RegWrite, IRWrite, PCUpdate, Branch and instr_done are forced to 0 regardless of state. Reset mid-instruction abandons it with no partial writes.
- Outputs are a Moore decode of state; signals not listed for a state are 0 (ALUSrc/ResultSrc/ALUOp = 00/000).
- ready = mem_ready when MEM_HANDSHAKE=1, else 1. A state marked "wait" holds, with its outputs held, until ready.
- FETCH (wait): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=010. IRWrite and PCUpdate are asserted only when ready. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (ALUOut <= OldPC+imm). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR; 0010011 -> EXECI
  - 1100011 -> BRANCH; 1101111 -> JUMP; 1100111 -> JALR
  - 0110111 -> LUI; 0010111 -> ALUWB (AUIPC)
  - anything else, or U-type with SUPPORT_UTYPE=0 -> FAULT
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD for load, MEMWRITE for store.
- MEMREAD (wait): AdrSrc=1, ResultSrc=000. Next: MEMWB.
- MEMWB: ResultSrc=001, RegWrite=1, instr_done=1. Next: FETCH.
- MEMWRITE (wait): AdrSrc=1, ResultSrc=000. MemWrite is asserted in every cycle of this state, including wait cycles; memory samples it on the ready cycle. instr_done=1 on the ready cycle. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB.
- ALUWB: ResultSrc=000, RegWrite=1, instr_done=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=000, Branch=1, instr_done=1. Next: FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (ALUOut <= rs1+imm). Next: JUMP.
- JUMP: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=000, PCUpdate=1 (PC <= ALUOut; ALU computes OldPC+4 for the link). Next: ALUWB.
- LUI: ResultSrc=011, RegWrite=1, instr_done=1. Next: FETCH.
- FAULT: all write enables 0, illegal_instr=1. Absorbing until reset; instr_done is never asserted.
- Cycles per instruction with no waits: lw 5, sw 4, R/I-ALU 4, branch 3, jal 4, jalr 5, lui 3, auipc 3. Each wait cycle adds 1.

Decomposition:
- Package riscv_ctrl_pkg: opcode constants, state enum, and encodings for ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc.
- Sub-module imm_src_decoder: combinational op -> ImmSrc, reused by the future pipelined core.

Test Plan:
- Reset, then lw (op 0000011), MEM_HANDSHAKE=0 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=001 in cycle 5 only; instr_done pulses once.
- sw, MEM_HANDSHAKE=1, mem_ready low for 2 cycles in MEMWRITE -> MemWrite held 3 cycles with AdrSrc=1; instr_done only on the ready cycle; total 6 cycles.
- beq (1100011) -> 3 cycles; Branch=1 with ALUOp=01, ALUSrcA=10, ALUSrcB=00 in cycle 3; RegWrite never 1.
- jalr (1100111) -> JALR then JUMP (PCUpdate=1, ALUSrcA=01, ALUSrcB=10), then ALUWB (RegWrite=1); 5 cycles total.
- op 0000000, and op 0110111 with SUPPORT_UTYPE=0 -> FAULT after DECODE; illegal_instr=1 and sticky; no write enables for 10+ cycles; reset clears it.
- Reset asserted in MEMWRITE during a wait -> MemWrite drops to 0 that cycle; next state is FETCH with IRWrite gated by mem_ready.
